register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 55 +++++
 1 files changed

// File: rtl/register_file.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file: two combinational read ports, one write port, x0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  WE3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_rd1_arr;
  logic [DATA_WIDTH-1:0] w_rd2_arr;

  assign w_wr_en = WE3 && (A3 != '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[A3] <= WD3;
    end
  end

  // Entry 0 is never written, but the read is still masked so x0 is zero by construction.
  assign w_rd1_arr = (A1 == '0) ? '0 : r_regs[A1];
  assign w_rd2_arr = (A2 == '0) ? '0 : r_regs[A2];

`ifdef REGFILE_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;

  assign w_fwd1 = w_wr_en && (A1 == A3);
  assign w_fwd2 = w_wr_en && (A2 == A3);

  assign RD1 = !RST ? '0 : (w_fwd1 ? WD3 : w_rd1_arr);
  assign RD2 = !RST ? '0 : (w_fwd2 ? WD3 : w_rd2_arr);
`else
  assign RD1 = !RST ? '0 : w_rd1_arr;
  assign RD2 = !RST ? '0 : w_rd2_arr;
`endif

endmodule
